// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial arbiter and sequencer for the single-port main RAM
// Serves store > load > fetch one access at a time; a flush drops speculative reads.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_flush,
  input  logic                  in_fetch_ce,
  input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
  output logic                  out_fetch_ce,
  output logic [DATA_WIDTH-1:0] out_fetch_inst,
  input  logic                  in_lsb_ce,
  input  logic [5:0]            in_lsb_size,
  input  logic                  in_lsb_signed,
  input  logic [ADDR_WIDTH-1:0] in_lsb_addr,
  output logic                  out_lsb_ce,
  output logic [DATA_WIDTH-1:0] out_lsb_data,
  input  logic                  in_rob_ce,
  input  logic [5:0]            in_rob_size,
  input  logic [ADDR_WIDTH-1:0] in_rob_addr,
  input  logic [DATA_WIDTH-1:0] in_rob_data,
  output logic                  out_rob_ce,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]            r_state;
  logic [5:0]            r_cnt;
  logic [5:0]            r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_sign;
  logic                  r_is_fetch;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_fetch_done, r_lsb_done, r_rob_done;
  logic [DATA_WIDTH-1:0] r_fetch_inst, r_lsb_data;

  logic                  r_f_vld, r_l_vld, r_s_vld;
  logic [ADDR_WIDTH-1:0] r_f_addr, r_l_addr, r_s_addr;
  logic [5:0]            r_l_size, r_s_size;
  logic                  r_l_sign;
  logic [DATA_WIDTH-1:0] r_s_data;

  // Merged view of pending slots and same-edge pulses; flush kills speculative reads.
  logic                  w_f_vld, w_l_vld, w_s_vld;
  logic [ADDR_WIDTH-1:0] w_f_addr, w_l_addr, w_s_addr;
  logic [5:0]            w_l_size, w_s_size;
  logic                  w_l_sign;
  logic [DATA_WIDTH-1:0] w_s_data;
  logic                  w_idle, w_take_s, w_take_l, w_take_f;
  logic [DATA_WIDTH-1:0] w_word, w_ext;

  assign w_f_vld  = (r_f_vld | in_fetch_ce) & ~in_flush;
  assign w_f_addr = in_fetch_ce ? in_fetch_addr : r_f_addr;
  assign w_l_vld  = (r_l_vld | in_lsb_ce) & ~in_flush;
  assign w_l_addr = in_lsb_ce ? in_lsb_addr : r_l_addr;
  assign w_l_size = in_lsb_ce ? in_lsb_size : r_l_size;
  assign w_l_sign = in_lsb_ce ? in_lsb_signed : r_l_sign;
  assign w_s_vld  = r_s_vld | in_rob_ce;
  assign w_s_addr = in_rob_ce ? in_rob_addr : r_s_addr;
  assign w_s_size = in_rob_ce ? in_rob_size : r_s_size;
  assign w_s_data = in_rob_ce ? in_rob_data : r_s_data;

  assign w_idle   = (r_state == S_IDLE);
  assign w_take_s = w_idle & w_s_vld;
  assign w_take_l = w_idle & ~w_s_vld & w_l_vld;
  assign w_take_f = w_idle & ~w_s_vld & ~w_l_vld & w_f_vld;

  // The last byte is still on mem_din at the done edge, so merge it in directly.
  always_comb begin
    w_word = r_buf;
    case (r_len)
      6'd1:    w_word[7:0]   = mem_din;
      6'd2:    w_word[15:8]  = mem_din;
      default: w_word[31:24] = mem_din;
    endcase
    w_ext = w_word;
    if (r_len == 6'd1)
      w_ext = {{(DATA_WIDTH-8){r_sign & w_word[7]}}, w_word[7:0]};
    else if (r_len == 6'd2)
      w_ext = {{(DATA_WIDTH-16){r_sign & w_word[15]}}, w_word[15:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;     r_cnt <= '0;        r_len <= '0;
      r_addr <= '0;          r_sign <= 1'b0;     r_is_fetch <= 1'b0;
      r_buf <= '0;           r_wdata <= '0;      r_wr <= 1'b0;
      r_mem_a <= '0;         r_mem_dout <= '0;
      r_fetch_done <= 1'b0;  r_lsb_done <= 1'b0; r_rob_done <= 1'b0;
      r_fetch_inst <= '0;    r_lsb_data <= '0;
      r_f_vld <= 1'b0;       r_l_vld <= 1'b0;    r_s_vld <= 1'b0;
      r_f_addr <= '0;        r_l_addr <= '0;     r_s_addr <= '0;
      r_l_size <= '0;        r_s_size <= '0;     r_l_sign <= 1'b0;
      r_s_data <= '0;
    end else begin
      r_fetch_done <= 1'b0;
      r_lsb_done   <= 1'b0;
      r_rob_done   <= 1'b0;
      if (rdy) begin
        r_f_vld  <= w_f_vld & ~w_take_f;
        r_f_addr <= w_f_addr;
        r_l_vld  <= w_l_vld & ~w_take_l;
        r_l_addr <= w_l_addr;
        r_l_size <= w_l_size;
        r_l_sign <= w_l_sign;
        r_s_vld  <= w_s_vld & ~w_take_s;
        r_s_addr <= w_s_addr;
        r_s_size <= w_s_size;
        r_s_data <= w_s_data;
        case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            if (w_take_s) begin
              r_state <= S_WRITE;  r_addr <= w_s_addr;  r_len <= w_s_size;
              r_wdata <= w_s_data; r_wr <= 1'b1;        r_mem_a <= w_s_addr;
              r_mem_dout <= w_s_data[7:0];
            end else if (w_take_l) begin
              r_state <= S_READ;   r_addr <= w_l_addr;  r_len <= w_l_size;
              r_sign <= w_l_sign;  r_is_fetch <= 1'b0;  r_mem_a <= w_l_addr;
            end else if (w_take_f) begin
              r_state <= S_READ;   r_addr <= w_f_addr;  r_len <= 6'd4;
              r_sign <= 1'b0;      r_is_fetch <= 1'b1;  r_mem_a <= w_f_addr;
            end
          end
          S_READ: begin
            if (in_flush) begin
              r_state <= S_IDLE;
            end else begin
              if (r_cnt + 6'd1 < r_len)
                r_mem_a <= r_addr + ADDR_WIDTH'(r_cnt + 6'd1);
              for (int i = 0; i < 4; i++)
                if (r_cnt != 6'd0 && r_cnt - 6'd1 == 6'(i))
                  r_buf[8*i +: 8] <= mem_din;
              if (r_cnt == r_len) begin
                r_state <= S_IDLE;
                if (r_is_fetch) begin
                  r_fetch_done <= 1'b1;
                  r_fetch_inst <= w_ext;
                end else begin
                  r_lsb_done <= 1'b1;
                  r_lsb_data <= w_ext;
                end
              end
              r_cnt <= r_cnt + 6'd1;
            end
          end
          S_WRITE: begin
            if (r_cnt + 6'd1 < r_len) begin
              r_mem_a    <= r_addr + ADDR_WIDTH'(r_cnt + 6'd1);
              r_mem_dout <= 8'(r_wdata >> {r_cnt + 6'd1, 3'b000});
              r_cnt      <= r_cnt + 6'd1;
            end else begin
              r_wr       <= 1'b0;
              r_rob_done <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_wr         = r_wr & rdy;
  assign mem_a          = r_mem_a;
  assign mem_dout       = r_mem_dout;
  assign out_fetch_ce   = r_fetch_done;
  assign out_fetch_inst = r_fetch_inst;
  assign out_lsb_ce     = r_lsb_done;
  assign out_lsb_data   = r_lsb_data;
  assign out_rob_ce     = r_rob_done;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
// Byte RAM with one-cycle read latency; expectations come from a golden byte array.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        in_flush = 1'b0;
  logic        in_fetch_ce = 1'b0;
  logic [31:0] in_fetch_addr = '0;
  logic        out_fetch_ce;
  logic [31:0] out_fetch_inst;
  logic        in_lsb_ce = 1'b0;
  logic [5:0]  in_lsb_size = 6'd1;
  logic        in_lsb_signed = 1'b0;
  logic [31:0] in_lsb_addr = '0;
  logic        out_lsb_ce;
  logic [31:0] out_lsb_data;
  logic        in_rob_ce = 1'b0;
  logic [5:0]  in_rob_size = 6'd1;
  logic [31:0] in_rob_addr = '0;
  logic [31:0] in_rob_data = '0;
  logic        out_rob_ce;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int total = 0;
  int bad = 0;

  bit [7:0]    ram  [0:65535];
  bit [7:0]    gold [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [31:0] bd_word = '0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush),
    .in_fetch_ce(in_fetch_ce), .in_fetch_addr(in_fetch_addr),
    .out_fetch_ce(out_fetch_ce), .out_fetch_inst(out_fetch_inst),
    .in_lsb_ce(in_lsb_ce), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
    .in_lsb_addr(in_lsb_addr), .out_lsb_ce(out_lsb_ce), .out_lsb_data(out_lsb_data),
    .in_rob_ce(in_rob_ce), .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr),
    .in_rob_data(in_rob_data), .out_rob_ce(out_rob_ce),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (bd_we) begin
      for (int i = 0; i < 4; i++) ram[16'(bd_addr + 16'(i))] <= bd_word[8*i +: 8];
    end else if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
    end
  end

  task automatic poke4(input logic [31:0] a, input logic [31:0] w);
    bd_addr = a[15:0]; bd_word = w; bd_we = 1'b1;
    for (int i = 0; i < 4; i++) gold[16'(a + 32'(i))] = w[8*i +: 8];
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(gold[16'(a + 32'(i))]) << (8*i));
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic issue_fetch(input logic [31:0] a);
    in_fetch_ce = 1'b1; in_fetch_addr = a;
    @(negedge clk);
    in_fetch_ce = 1'b0;
  endtask

  task automatic issue_load(input logic [31:0] a, input int n, input bit sgn);
    in_lsb_ce = 1'b1; in_lsb_addr = a; in_lsb_size = 6'(n); in_lsb_signed = sgn;
    @(negedge clk);
    in_lsb_ce = 1'b0;
  endtask

  task automatic issue_store(input logic [31:0] a, input int n, input logic [31:0] d);
    in_rob_ce = 1'b1; in_rob_addr = a; in_rob_size = 6'(n); in_rob_data = d;
    for (int i = 0; i < n; i++) gold[16'(a + 32'(i))] = d[8*i +: 8];
    @(negedge clk);
    in_rob_ce = 1'b0;
  endtask

  // cyc = k when the done pulse was registered at edge E(k) after the accept edge.
  task automatic wait_done(input int which, input int limit, output bit got, output int cyc);
    got = 1'b0; cyc = 0;
    while (!got && cyc < limit) begin
      @(negedge clk);
      cyc++;
      case (which)
        0:       got = out_fetch_ce;
        1:       got = out_lsb_ce;
        default: got = out_rob_ce;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
    total++; if ({out_fetch_ce, out_lsb_ce, out_rob_ce} !== 3'b000) begin
      bad++; $display("FAIL reset_done: got %b want 000", {out_fetch_ce, out_lsb_ce, out_rob_ce}); end
    total++; if ({out_fetch_inst, out_lsb_data} !== 64'h0) begin
      bad++; $display("FAIL reset_data: got %h %h want 0", out_fetch_inst, out_lsb_data); end
    rst = 1'b1; rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    bit got; int cyc;
    poke4(32'h1000, 32'h0000_0513);
    issue_fetch(32'h1000);
    for (int k = 0; k < 4; k++) begin
      total++; if (mem_a !== 32'h1000 + 32'(k)) begin bad++; $display("FAIL fetch_addr[%0d]: got %h want %h", k, mem_a, 32'h1000 + 32'(k)); end
      total++; if (out_fetch_ce !== 1'b0) begin bad++; $display("FAIL fetch_early[%0d]: got %b want 0", k, out_fetch_ce); end
      @(negedge clk);
    end
    wait_done(0, 20, got, cyc);
    total++; if (!got || cyc != 1) begin bad++; $display("FAIL fetch_done_e5: got %0b at +%0d want 1 at +1", got, cyc); end
    total++; if (out_fetch_inst !== 32'h0000_0513) begin bad++; $display("FAIL fetch_inst: got %h want 00000513", out_fetch_inst); end
    @(negedge clk);
    total++; if (out_fetch_ce !== 1'b0) begin bad++; $display("FAIL fetch_pulse_width: got %b want 0", out_fetch_ce); end
  endtask

  task automatic test_load_ext();
    logic [31:0] ta [6] = '{32'h20, 32'h20, 32'h30, 32'h30, 32'hFFFF_FFFF, 32'h30};
    int          tn [6] = '{1, 1, 2, 2, 2, 4};
    bit          ts [6] = '{1, 0, 1, 0, 1, 1};
    logic [31:0] te [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_F234, 32'h0000_F234,
                            32'hFFFF_819C, 32'h0000_F234};
    bit got; int cyc;
    poke4(32'h20, 32'h0000_0080);
    poke4(32'h30, 32'h0000_F234);
    poke4(32'hFFFC, 32'h9C00_0000);
    poke4(32'h0, 32'h0000_0081);
    for (int k = 0; k < 6; k++) begin
      issue_load(ta[k], tn[k], ts[k]);
      wait_done(1, 20, got, cyc);
      total++; if (!got || cyc != tn[k] + 1) begin bad++; $display("FAIL load_latency[%0d]: got %0b at %0d want %0d", k, got, cyc, tn[k] + 1); end
      total++; if (out_lsb_data !== te[k]) begin bad++; $display("FAIL load_data[%0d]: got %h want %h", k, out_lsb_data, te[k]); end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [31:0] d = 32'hDEAD_BEEF;
    bit got; int cyc;
    issue_store(32'h40, 4, d);
    for (int k = 0; k < 4; k++) begin
      total++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h40 + 32'(k), d[8*k +: 8]}) begin
        bad++; $display("FAIL store_beat[%0d]: got wr=%b a=%h d=%h want wr=1 a=%h d=%h", k, mem_wr, mem_a, mem_dout, 32'h40 + 32'(k), d[8*k +: 8]); end
      total++; if (out_rob_ce !== 1'b0) begin bad++; $display("FAIL store_early[%0d]: got %b want 0", k, out_rob_ce); end
      @(negedge clk);
    end
    total++; if ({mem_wr, out_rob_ce} !== 2'b01) begin bad++; $display("FAIL store_end: got wr=%b ce=%b want wr=0 ce=1", mem_wr, out_rob_ce); end
    @(negedge clk);
    issue_load(32'h40, 4, 1'b0);
    wait_done(1, 20, got, cyc);
    total++; if (!got || out_lsb_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_readback: got %h want deadbeef", out_lsb_data); end
    @(negedge clk);
  endtask

  task automatic test_priority();
    int rob_at = -1, lsb_at = -1, f_at = -1, wr_n = 0, wr_max = -1;
    int ns = 2, nl = 2;
    int exp_rob, exp_lsb, exp_f;
    logic [31:0] exp_ld, exp_fi;
    poke4(32'h1100, 32'h1234_5678);
    poke4(32'h1200, 32'hA5B6_C7D8);
    exp_ld = model_load(32'h1200, nl, 1'b1);
    exp_fi = model_load(32'h1100, 4, 1'b0);
    in_fetch_ce = 1'b1; in_fetch_addr = 32'h1100;
    in_lsb_ce = 1'b1; in_lsb_addr = 32'h1200; in_lsb_size = 6'(nl); in_lsb_signed = 1'b1;
    in_rob_ce = 1'b1; in_rob_addr = 32'h1300; in_rob_size = 6'(ns); in_rob_data = 32'h0000_4321;
    for (int i = 0; i < ns; i++) gold[16'(32'h1300 + 32'(i))] = in_rob_data[8*i +: 8];
    @(negedge clk);
    in_fetch_ce = 1'b0; in_lsb_ce = 1'b0; in_rob_ce = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (mem_wr) begin wr_n++; wr_max = c; end
      if (out_rob_ce && rob_at < 0) rob_at = c;
      if (out_lsb_ce && lsb_at < 0) begin lsb_at = c; total++;
        if (out_lsb_data !== exp_ld) begin bad++; $display("FAIL prio_load_data: got %h want %h", out_lsb_data, exp_ld); end end
      if (out_fetch_ce && f_at < 0) begin f_at = c; total++;
        if (out_fetch_inst !== exp_fi) begin bad++; $display("FAIL prio_fetch_data: got %h want %h", out_fetch_inst, exp_fi); end end
    end
    exp_rob = ns; exp_lsb = ns + 1 + nl + 1; exp_f = exp_lsb + 1 + 4 + 1;
    total++; if (rob_at != exp_rob || lsb_at != exp_lsb || f_at != exp_f) begin
      bad++; $display("FAIL prio_order: got rob=%0d lsb=%0d fetch=%0d want %0d %0d %0d", rob_at, lsb_at, f_at, exp_rob, exp_lsb, exp_f); end
    total++; if (wr_n != ns || wr_max != ns - 1) begin bad++; $display("FAIL prio_write_beats: got n=%0d last=%0d want %0d %0d", wr_n, wr_max, ns, ns - 1); end
  endtask

  task automatic test_flush();
    bit got; int cyc; int n_f = 0, n_l = 0, rob1 = -1, rob2 = -1;
    logic [31:0] d1, d2, exp;
    poke4(32'h1400, $urandom());
    issue_fetch(32'h1400);
    @(negedge clk);
    in_lsb_ce = 1'b1; in_lsb_addr = 32'h30; in_lsb_size = 6'd2; in_lsb_signed = 1'b0;
    @(negedge clk);
    in_lsb_ce = 1'b0;
    total++; if (mem_a !== 32'h1402) begin bad++; $display("FAIL flush_beat3_addr: got %h want 1402", mem_a); end
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    total++; if ({out_fetch_ce, out_lsb_ce} !== 2'b00 || mem_a !== 32'h1402) begin
      bad++; $display("FAIL flush_abort: got f=%b l=%b a=%h want 0 0 1402", out_fetch_ce, out_lsb_ce, mem_a); end
    issue_load(32'h20, 1, 1'b0);
    wait_done(1, 20, got, cyc);
    total++; if (!got || cyc != 2 || out_lsb_data !== 32'h80) begin
      bad++; $display("FAIL flush_idle_next: got %0b at %0d data %h want 1 at 2 data 00000080", got, cyc, out_lsb_data); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_f += int'(out_fetch_ce); n_l += int'(out_lsb_ce);
    end
    total++; if (n_f != 0 || n_l != 0) begin bad++; $display("FAIL flush_no_done: got fetch=%0d load=%0d want 0 0", n_f, n_l); end

    d1 = $urandom(); d2 = $urandom();
    issue_store(32'h1500, 4, d1);
    in_fetch_ce = 1'b1; in_fetch_addr = 32'h1400;
    @(negedge clk);
    in_fetch_ce = 1'b0;
    @(negedge clk);
    in_flush = 1'b1;
    in_rob_ce = 1'b1; in_rob_addr = 32'h1600; in_rob_size = 6'd1; in_rob_data = d2;
    gold[16'h1600] = d2[7:0];
    @(negedge clk);
    in_flush = 1'b0; in_rob_ce = 1'b0; n_f = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (out_rob_ce) begin if (rob1 < 0) rob1 = c; else if (rob2 < 0) rob2 = c; end
      n_f += int'(out_fetch_ce);
    end
    total++; if (rob1 != 1 || rob2 != 3) begin bad++; $display("FAIL flush_store_done: got %0d %0d want 1 3", rob1, rob2); end
    total++; if (n_f != 0) begin bad++; $display("FAIL flush_fetch_dropped: got %0d want 0", n_f); end
    exp = model_load(32'h1500, 4, 1'b0);
    issue_load(32'h1500, 4, 1'b0);
    wait_done(1, 20, got, cyc);
    total++; if (!got || out_lsb_data !== exp) begin bad++; $display("FAIL flush_store_data: got %h want %h", out_lsb_data, exp); end
    @(negedge clk);
    exp = model_load(32'h1600, 1, 1'b0);
    issue_load(32'h1600, 1, 1'b0);
    wait_done(1, 20, got, cyc);
    total++; if (!got || out_lsb_data !== exp) begin bad++; $display("FAIL flush_edge_store: got %h want %h", out_lsb_data, exp); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit got; int cyc; int n_f = 0;
    logic [31:0] d, exp;
    d = $urandom();
    issue_store(32'h1700, 4, d);
    @(negedge clk);
    rdy = 1'b0;
    in_fetch_ce = 1'b1; in_fetch_addr = 32'h1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL stall_wr[%0d]: got %b want 0", k, mem_wr); end
      @(negedge clk);
      in_fetch_ce = 1'b0;
    end
    rdy = 1'b1;
    wait_done(2, 20, got, cyc);
    total++; if (!got || cyc != 3) begin bad++; $display("FAIL stall_store_done: got %0b at %0d want 1 at 3", got, cyc); end
    for (int c = 0; c < 10; c++) begin @(negedge clk); n_f += int'(out_fetch_ce); end
    total++; if (n_f != 0) begin bad++; $display("FAIL stall_pulse_ignored: got %0d fetch dones want 0", n_f); end
    exp = model_load(32'h1700, 4, 1'b0);
    issue_load(32'h1700, 4, 1'b0);
    wait_done(1, 20, got, cyc);
    total++; if (!got || out_lsb_data !== exp) begin bad++; $display("FAIL stall_ram: got %h want %h", out_lsb_data, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    int n_l = 0;
    poke4(32'h1800, $urandom());
    issue_load(32'h1800, 4, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if ({mem_wr, mem_a, mem_dout, out_fetch_ce, out_lsb_ce, out_rob_ce, out_fetch_inst, out_lsb_data} !== '0) begin
      bad++; $display("FAIL reset_mid_read: got a=%h inst=%h data=%h want all 0", mem_a, out_fetch_inst, out_lsb_data); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin @(negedge clk); n_l += int'(out_lsb_ce); end
    total++; if (n_l != 0) begin bad++; $display("FAIL reset_no_done: got %0d want 0", n_l); end
  endtask

  task automatic test_random();
    int op, n, cyc; bit sgn, got;
    logic [31:0] a, d, exp;
    for (int i = 0; i < 16; i++) poke4(32'h2000 + 32'(4*i), $urandom());
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 2);
      a = 32'h2000 + 32'($urandom_range(0, 60));
      case ($urandom_range(0, 2)) 0: n = 1; 1: n = 2; default: n = 4; endcase
      sgn = 1'($urandom_range(0, 1));
      d = $urandom();
      if (op == 0) begin
        issue_store(a, n, d);
        wait_done(2, 20, got, cyc);
        total++; if (!got || cyc != n) begin bad++; $display("FAIL rand_store[%0d]: got %0b at %0d want 1 at %0d", k, got, cyc, n); end
      end else if (op == 1) begin
        exp = model_load(a, n, sgn);
        issue_load(a, n, sgn);
        wait_done(1, 20, got, cyc);
        total++; if (!got || cyc != n + 1 || out_lsb_data !== exp) begin
          bad++; $display("FAIL rand_load[%0d]: got %h at %0d want %h at %0d", k, out_lsb_data, cyc, exp, n + 1); end
      end else begin
        exp = model_load(a, 4, 1'b0);
        issue_fetch(a);
        wait_done(0, 20, got, cyc);
        total++; if (!got || cyc != 5 || out_fetch_inst !== exp) begin
          bad++; $display("FAIL rand_fetch[%0d]: got %h at %0d want %h at 5", k, out_fetch_inst, cyc, exp); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fetch();
    test_load_ext();
    test_store();
    test_priority();
    test_flush();
    test_stall();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Arbiter and sequencer for the single-port, byte-wide main RAM. It serves three requesters:
- the fetcher (4-byte instruction reads),
- the LSB (1/2/4-byte loads with sign control),
- the ROB (1/2/4-byte committed stores).

Multi-byte accesses are serialized into byte beats, read data is assembled little-endian, and each requester gets a one-cycle done pulse. A ROB flush cancels speculative fetch and load traffic.

Parameters:
ADDR_WIDTH, 32, width of all address ports and mem_a
DATA_WIDTH, 32, width of assembled read/write data

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low freezes all state
in_flush  in  1  ROB mispredict flush
in_fetch_ce  in  1  fetch request pulse
in_fetch_addr  in  ADDR_WIDTH  instruction address
out_fetch_ce  out  1  fetch done pulse
out_fetch_inst  out  DATA_WIDTH  instruction word
in_lsb_ce  in  1  load request pulse
in_lsb_size  in  6  bytes: 1, 2 or 4
in_lsb_signed  in  1  1 = sign-extend
in_lsb_addr  in  ADDR_WIDTH  load address
out_lsb_ce  out  1  load done pulse
out_lsb_data  out  DATA_WIDTH  extended load data
in_rob_ce  in  1  store request pulse
in_rob_size  in  6  bytes: 1, 2 or 4
in_rob_addr  in  ADDR_WIDTH  store address
in_rob_data  in  DATA_WIDTH  store data
out_rob_ce  out  1  store done pulse
mem_din  in  8  RAM read byte; reflects the mem_a of the previous cycle
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_WIDTH  RAM byte address
mem_wr  out  1  1 = write

Behaviour:
Reset and stall:
- rst low (async): state IDLE; all pending flags clear; all outputs 0.
- rdy low: no register updates and request pulses are ignored; mem_wr is forced to 0 combinationally. On resume, the current beat is replayed.

Request capture:
- Each requester has one pending slot (valid, addr, size, signed, data), set by its ce pulse.
- A new fetch pulse overwrites a pending fetch.
- LSB and ROB never issue a second pulse while pending; behaviour in that case is undefined.

Arbitration:
- Evaluated only in IDLE, including pulses arriving on the same edge.
- Priority: store > load > fetch.
- The selected slot clears on acceptance.

FSM states: IDLE, READ, WRITE.

READ, N bytes, accept edge E0:
- Beat i (i = 0..N-1) drives mem_a = addr+i during the cycle after E(i).
- mem_din is captured into byte i at edge E(i+2).
- At E(N+1): done pulse = 1 and data output registered, state returns to IDLE.
- Next accept is possible at E(N+2).
- Addresses increment modulo 2^ADDR_WIDTH.

WRITE, N bytes:
- Cycles after E0..E(N-1): mem_wr = 1, mem_a = addr+i, mem_dout = data[8i+7:8i].
- At EN: mem_wr = 0, out_rob_ce = 1, state returns to IDLE.

Data extension:
- size 1: bits [31:8] = signed ? bit7 : 0.
- size 2: bits [31:16] = signed ? bit15 : 0.
- size 4: raw word.
- Fetch reads are always size 4, unsigned.

Done signals:
- All done pulses are exactly one cycle and default to 0 every cycle.
- Data outputs hold their value until the next done.

Flush (in_flush high at an edge):
- Pending fetch and load slots are cleared.
- An active READ aborts to IDLE with no done pulse; a READ accepted on that same edge is also dropped.
- Pending and active stores are unaffected.
- A store pulse on the flush edge is still captured.
- Fetch or load pulses on the flush edge are discarded.

Outside WRITE: mem_wr = 0; mem_a holds its last value.

Test Plan:
- Fetch 0x1000, RAM[0x1000..3] = 13,05,00,00 -> mem_a steps 0x1000..0x1003; out_fetch_ce one cycle at E5; out_fetch_inst = 0x00000513.
- LB at 0x20, RAM byte 0x80, signed = 1 -> out_lsb_data = 0xFFFFFF80. LBU at the same address -> 0x00000080. LH signed on bytes 0x34,0xF2 -> 0xFFFFF234.
- Store size 4, addr 0x40, data 0xDEADBEEF -> four write cycles, mem_dout EF,BE,AD,DE; out_rob_ce at E4; a following LW at 0x40 returns 0xDEADBEEF.
- Fetch, load and store pulses on the same edge while IDLE -> store serviced first, then load, then fetch; no beats overlap.
- Flush during the 3rd beat of a fetch, with a load pending -> no out_fetch_ce, no out_lsb_ce, FSM IDLE next cycle. Same test with a store active -> store completes and out_rob_ce fires.
- rdy low for 3 cycles mid-WRITE -> mem_wr = 0 while low; RAM contents after completion equal the no-stall result. Reset asserted mid-READ -> all outputs 0 immediately, no done pulse.
